// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: the word is cut into STAGES slices, one slice per stage,
// with a ripple of registered slice carries and a valid/ready handshake with global stall.
module cla_pipe_adder #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4,
  parameter int unsigned GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             P0,
  output logic             G0
);

  localparam int unsigned SW = WIDTH / STAGES;
  localparam int unsigned NG = SW / GROUP;

  typedef struct packed {
    logic [SW-1:0] sum;
    logic          cout;
    logic          cmsb;
    logic          p;
    logic          g;
  } slice_t;

  // Two-level lookahead: bit carries from the group carry-in, group carries from group P/G.
  function automatic slice_t cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                       input logic c0);
    slice_t        r;
    logic [SW-1:0] gb, pb;
    logic [SW:0]   c;
    logic          gg, gp, sg, sp;
    int unsigned   base;
    gb   = x & y;
    pb   = x ^ y;
    c    = '0;
    c[0] = c0;
    sg   = 1'b0;
    sp   = 1'b1;
    for (int unsigned i = 0; i < NG; i++) begin
      base = i * GROUP;
      gg   = 1'b0;
      gp   = 1'b1;
      for (int unsigned j = 0; j < GROUP; j++) begin
        if (j > 0) c[base+j] = gg | (gp & c[base]);
        gg = gb[base+j] | (pb[base+j] & gg);
        gp = gp & pb[base+j];
      end
      c[base+GROUP] = gg | (gp & c[base]);
      sg = gg | (gp & sg);
      sp = sp & gp;
    end
    r.sum  = pb ^ c[SW-1:0];
    r.cout = c[SW];
    r.cmsb = c[SW-1];
    r.p    = sp;
    r.g    = sg;
    return r;
  endfunction

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [STAGES-1:0] pp_q, pp_d;
  logic [STAGES-1:0] gg_q, gg_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              ovf_q, ovf_d;

  assign out_valid = vld_q[STAGES-1];
  assign in_ready  = ~out_valid | out_ready;
  assign s         = sum_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];
  assign ovf       = ovf_q;
  assign P0        = pp_q[STAGES-1];
  assign G0        = gg_q[STAGES-1];

  always_comb begin : p_stage
    slice_t           sl;
    logic [WIDTH-1:0] ax, bx, sx;
    logic             cx, vx, px, gx;
    int unsigned      km1;
    sl    = '0;
    ax    = '0;
    bx    = '0;
    sx    = '0;
    cx    = 1'b0;
    vx    = 1'b0;
    px    = 1'b1;
    gx    = 1'b0;
    km1   = 0;
    ovf_d = 1'b0;
    vld_d = '0;
    cy_d  = '0;
    pp_d  = '0;
    gg_d  = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      km1 = (k == 0) ? 32'd0 : k - 1;
      if (k == 0) begin
        ax = a;
        bx = sub ? ~b : b;
        cx = cin;
        vx = in_valid;
        px = 1'b1;
        gx = 1'b0;
        sx = '0;
      end else begin
        ax = a_q[km1];
        bx = b_q[km1];
        cx = cy_q[km1];
        vx = vld_q[km1];
        px = pp_q[km1];
        gx = gg_q[km1];
        sx = sum_q[km1];
      end
      sl                   = cla_slice(ax[k*SW +: SW], bx[k*SW +: SW], cx);
      a_d[k]               = ax;
      b_d[k]               = bx;
      sum_d[k]             = sx;
      sum_d[k][k*SW +: SW] = sl.sum;
      vld_d[k]             = vx;
      cy_d[k]              = sl.cout;
      pp_d[k]              = px & sl.p;
      gg_d[k]              = sl.g | (sl.p & gx);
      if (k == STAGES - 1) ovf_d = sl.cmsb ^ sl.cout;
    end
  end

  // A stalled output freezes every stage, so bubbles and data never overtake each other.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      pp_q  <= '0;
      gg_q  <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (in_ready) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      pp_q  <= pp_d;
      gg_q  <= gg_d;
      ovf_q <= ovf_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed vectors, stall/reset sequences and random streams on
// three parameter sets, scored against an arithmetic reference model.
module tb_cla_pipe_adder;

  typedef struct {
    logic [63:0] s;
    logic        cout, ovf, p, g;
    int          id;
    int          t;
  } exp_t;

  typedef struct {
    logic [63:0] a, b;
    logic        cin, sub;
    logic [63:0] s;
    logic        cout, ovf, p, g;
  } vec_t;

  logic        clk, rst_n, cin, sub, iv_main, iv_aux, or_main, or_aux;
  logic [63:0] a, b;
  logic [2:0]  ivl, ordy, irdy, ov, oc, oo, op, og, lat_on;
  logic [63:0] s_main, s_s1;
  logic [31:0] s_w32;
  logic [63:0] os [3];
  int          wid [3];
  int          stg [3];
  int          errors, checks, cyc;
  exp_t        q [$];
  vec_t        tv [8];

  assign ivl   = {iv_aux, iv_aux, iv_main};
  assign ordy  = {or_aux, or_aux, or_main};
  assign os[0] = s_main;
  assign os[1] = {32'd0, s_w32};
  assign os[2] = s_s1;

  cla_pipe_adder #(.WIDTH(64), .STAGES(4), .GROUP(4)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_main), .in_ready(irdy[0]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(or_main), .s(s_main),
    .cout(oc[0]), .ovf(oo[0]), .P0(op[0]), .G0(og[0])
  );

  cla_pipe_adder #(.WIDTH(32), .STAGES(2), .GROUP(4)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_aux), .in_ready(irdy[1]), .a(a[31:0]),
    .b(b[31:0]), .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(or_aux), .s(s_w32),
    .cout(oc[1]), .ovf(oo[1]), .P0(op[1]), .G0(og[1])
  );

  cla_pipe_adder #(.WIDTH(64), .STAGES(1), .GROUP(4)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_aux), .in_ready(irdy[2]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(or_aux), .s(s_s1),
    .cout(oc[2]), .ovf(oo[2]), .P0(op[2]), .G0(og[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // Plain wide arithmetic; overflow from operand/result signs rather than carries.
  function automatic exp_t ref_calc(input int w, input logic [63:0] x, input logic [63:0] y,
                                    input logic ci, input logic sb);
    exp_t        r;
    logic [64:0] mask, xa, yb, t, g;
    mask   = (65'd1 << w) - 65'd1;
    xa     = {1'b0, x} & mask;
    yb     = (sb ? {1'b0, ~y} : {1'b0, y}) & mask;
    t      = xa + yb + {64'd0, ci};
    g      = xa + yb;
    r.s    = t[63:0] & mask[63:0];
    r.cout = t[w];
    r.ovf  = (xa[w-1] == yb[w-1]) && (t[w-1] != xa[w-1]);
    r.p    = ((xa ^ yb) == mask);
    r.g    = g[w];
    r.id   = 0;
    r.t    = 0;
    return r;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    int   idx;
    if (!rst_n) begin
      q.delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (ivl[k] && irdy[k]) begin
          e    = ref_calc(wid[k], a, b, cin, sub);
          e.id = k;
          e.t  = cyc;
          q.push_back(e);
        end
        if (ov[k]) begin
          idx = -1;
          for (int i = 0; i < q.size(); i++) if (idx < 0 && q[i].id == k) idx = i;
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out dut%0d: got out_valid=1 required no pending result", k);
          end else begin
            chk($sformatf("sum dut%0d", k), os[k], q[idx].s);
            chk($sformatf("cout_ovf_p_g dut%0d", k), {60'd0, oc[k], oo[k], op[k], og[k]},
                {60'd0, q[idx].cout, q[idx].ovf, q[idx].p, q[idx].g});
            if (ordy[k]) begin
              if (lat_on[k]) chk($sformatf("latency dut%0d", k), 64'(cyc - q[idx].t),
                                 64'(stg[k]));
              q.delete(idx);
            end
          end
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 64'(q.size()), 64'd0);
  endtask

  task automatic rand_ops();
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int  n, i, t;
    bit  acc;
    logic [63:0] ones;
    ones   = '1;
    wid[0] = 64; wid[1] = 32; wid[2] = 64;
    stg[0] = 4;  stg[1] = 2;  stg[2] = 1;
    errors = 0; checks = 0; cyc = 0;
    rst_n = 1'b0; iv_main = 1'b0; iv_aux = 1'b0; or_main = 1'b1; or_aux = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; lat_on = 3'b111;

    tv[0] = '{64'd5, 64'd12, 1'b0, 1'b0, 64'd17, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{ones, ones, 1'b1, 1'b0, ones, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[2] = '{64'd5, 64'd12, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3] = '{64'd12, 64'd5, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000,
              1'b0, 1'b1, 1'b0, 1'b0};
    tv[5] = '{ones, ones, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[6] = '{64'd0, ones, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[7] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF,
              1'b1, 1'b1, 1'b0, 1'b1};

    // Power-up reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {61'd0, ov}, 64'd0);
    chk("reset s", s_main, 64'd0);
    chk("reset flags", {60'd0, oc[0], oo[0], op[0], og[0]}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after reset", {63'd0, irdy[0]}, 64'd1);

    // Directed vectors through the 4-stage instance
    for (int v = 0; v < 8; v++) begin
      @(posedge clk);
      #1;
      a = tv[v].a; b = tv[v].b; cin = tv[v].cin; sub = tv[v].sub; iv_main = 1'b1;
      @(posedge clk);
      #1;
      iv_main = 1'b0;
      n = 1;
      while (!ov[0] && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("vec%0d latency", v), 64'(n), 64'd4);
      chk($sformatf("vec%0d s", v), s_main, tv[v].s);
      chk($sformatf("vec%0d cout_ovf_p_g", v), {60'd0, oc[0], oo[0], op[0], og[0]},
          {60'd0, tv[v].cout, tv[v].ovf, tv[v].p, tv[v].g});
    end
    drain();

    // Back-to-back stream with out_ready dropped for three cycles
    lat_on[0] = 1'b0;
    i = 0;
    t = 0;
    rand_ops();
    while (i < 8 && t < 60) begin
      or_main = !(t >= 5 && t <= 7);
      iv_main = 1'b1;
      @(negedge clk);
      acc = irdy[0];
      if (ov[0] && !or_main) chk("in_ready during stall", {63'd0, irdy[0]}, 64'd0);
      @(posedge clk);
      #1;
      t++;
      if (acc) begin
        i++;
        rand_ops();
      end
    end
    iv_main = 1'b0;
    or_main = 1'b1;
    chk("stall stream accepted", 64'(i), 64'd8);
    drain();

    // Random in_valid/out_ready on the 4-stage instance
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      rand_ops();
      iv_main = 1'($urandom_range(0, 1));
      or_main = ($urandom_range(0, 3) != 0);
    end
    iv_main = 1'b0;
    or_main = 1'b1;
    drain();

    // Unstalled random stream on all three parameter sets, latency checked
    lat_on = 3'b111;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      rand_ops();
      iv_main = ($urandom_range(0, 3) != 0);
      iv_aux  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    iv_main = 1'b0;
    iv_aux  = 1'b0;
    drain();

    // Reset with three transactions in flight
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      rand_ops();
      a[63]   = 1'b1;
      iv_main = 1'b1;
      iv_aux  = 1'b1;
    end
    @(posedge clk);
    #1;
    iv_main = 1'b0;
    iv_aux  = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midreset out_valid", {61'd0, ov}, 64'd0);
    chk("midreset s", s_main, 64'd0);
    chk("midreset flags", {60'd0, oc[0], oo[0], op[0], og[0]}, 64'd0);
    chk("midreset in_ready", {63'd0, irdy[0]}, 64'd1);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      chk("no stale result", {61'd0, ov}, 64'd0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
